// File: rtl/dmem_if.sv
// Valid/ready request and response channels between the CPU load/store port
// (master) and the data-memory responder (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one word request at a time, LATENCY wait states,
// byte-masked store or load on a local word array, held response.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus,
  output logic   busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q;
  logic          wr_p0;
  logic [31:0]   addr_p0, wdata_p0;
  logic [3:0]    wstrb_p0;
  logic [31:0]   rdata_p1;
  logic          err_p1;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept, access;
  logic          acc_write, acc_err;
  logic [31:0]   acc_addr, acc_wdata;
  logic [3:0]    acc_wstrb;
  logic [AW-1:0] acc_idx;

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH_WORDS));
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++)
      m[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return m;
  endfunction

  // With LATENCY=0 the access happens in the accept cycle, so live inputs are used.
  assign accept = (state_q == IDLE) && bus.req_valid && !rst;
  assign access = (LATENCY == 0) ? accept : ((state_q == WAIT) && (cnt_q == '0));

  always_comb begin
    acc_write = wr_p0;
    acc_addr  = addr_p0;
    acc_wdata = wdata_p0;
    acc_wstrb = wstrb_p0;
    if (state_q == IDLE) begin
      acc_write = bus.req_write;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_wstrb = bus.req_wstrb;
    end
  end

  assign acc_idx = acc_addr[2 +: AW];
  assign acc_err = addr_err(acc_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    busy          = (state_q != IDLE);
  end

  assign bus.rsp_rdata = rdata_p1;
  assign bus.rsp_err   = err_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  cnt_q <= '0;
    else if (accept)                          cnt_q <= LAT_M1;
    else if (state_q == WAIT && cnt_q != '0)  cnt_q <= cnt_q - 4'd1;
  end

  // p0: request capture, so the requester may change req_* after the handshake
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_p0    <= bus.req_write;
      addr_p0  <= bus.req_addr;
      wdata_p0 <= bus.req_wdata;
      wstrb_p0 <= bus.req_wstrb;
    end
  end

  // p1: memory access result, held until the response handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else if (access) begin
      err_p1   <= acc_err;
      rdata_p1 <= (acc_err || acc_write) ? 32'd0 : mem[acc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (access && acc_write && !acc_err)
      mem[acc_idx] <= merge_lanes(mem[acc_idx], acc_wdata, acc_wstrb);
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder with a transaction-level memory model,
// plus directed scenarios and a LATENCY=0 instance.
module tb_dmem_responder;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  logic clk, rst, busy, busy0;
  int n_cmp, n_bad;

  dmem_if bus ();
  dmem_if bus0 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .busy(busy0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding request, result due LAT edges after accept.
  logic [31:0] m_mem [DEPTH];
  bit          m_pend, m_resp;
  int          m_cyc, m_due;
  logic        m_wr, m_err;
  logic [31:0] m_addr, m_wd, m_rd;
  logic [3:0]  m_st;

  task automatic m_do_access();
    int idx;
    m_err = (m_addr[1:0] != 2'b00) || ((m_addr >> 2) >= 32'(DEPTH));
    m_rd  = 32'd0;
    if (!m_err) begin
      idx = int'(m_addr >> 2);
      if (m_wr) begin
        for (int i = 0; i < 4; i++)
          if (m_st[i]) m_mem[idx][8*i +: 8] = m_wd[8*i +: 8];
      end else begin
        m_rd = m_mem[idx];
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 1'b0;
      m_resp = 1'b0;
    end else begin
      m_cyc++;
      if (m_resp) begin
        if (bus.rsp_ready) m_resp = 1'b0;
      end else if (m_pend) begin
        if (m_cyc == m_due) begin
          m_do_access();
          m_pend = 1'b0;
          m_resp = 1'b1;
        end
      end else if (bus.req_valid) begin
        m_wr = bus.req_write; m_addr = bus.req_addr;
        m_wd = bus.req_wdata; m_st = bus.req_wstrb;
        if (LAT == 0) begin
          m_do_access();
          m_resp = 1'b1;
        end else begin
          m_pend = 1'b1;
          m_due  = m_cyc + LAT;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk1("req_ready", bus.req_ready, !m_pend && !m_resp);
      chk1("busy", busy, m_pend || m_resp);
      chk1("rsp_valid", bus.rsp_valid, m_resp);
      if (m_resp) begin
        chk("rsp_rdata", bus.rsp_rdata, m_rd);
        chk1("rsp_err", bus.rsp_err, m_err);
      end
    end
  end

  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input int hold, input logic pre, input logic poke,
                      output logic [31:0] rd, output logic er);
    int n, lat;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
    bus.req_wdata = wd;   bus.req_wstrb = st; bus.rsp_ready = pre;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.req_ready && n < 50);
    chk1("accept_bound", n < 50, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom); bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;     bus.req_wstrb = 4'($urandom);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.rsp_valid && lat < 50);
    chk("rsp_latency", 32'(lat), 32'(LAT + 1));
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    if (!pre) begin
      for (int i = 0; i < hold; i++) begin
        if (poke) begin
          bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h0;
          bus.req_wdata = 32'hFFFF_FFFF; bus.req_wstrb = 4'hF;
        end
        @(negedge clk);
        chk1("hold_req_ready", bus.req_ready, 1'b0);
        chk1("hold_rsp_valid", bus.rsp_valid, 1'b1);
        chk("hold_rdata", bus.rsp_rdata, rd);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          sel;
    logic [31:0] a;
    n_cmp = 0; n_bad = 0; m_cyc = 0;
    rst = 1'b1;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.req_wstrb = 0; bus.rsp_ready = 0;
    bus0.req_valid = 0; bus0.req_write = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
    bus0.req_wstrb = 0; bus0.rsp_ready = 0;
    #1;
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    chk1("rst_err", bus.rsp_err, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("rst_req_ready", bus.req_ready, 1'b1);

    for (int i = 0; i < DEPTH; i++)
      xact(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b1, 1'b0, rd, er);

    // Store/load round trip
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 1'b0, rd, er);
    chk("t1_store_rdata", rd, 32'h0);
    chk1("t1_store_err", er, 1'b0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, 1'b0, rd, er);
    chk("t1_load_rdata", rd, 32'hDEADBEEF);
    chk1("t1_load_err", er, 1'b0);

    // Byte-lane masking
    xact(1'b1, 32'h20, 32'h11223344, 4'hF, 1, 1'b0, 1'b0, rd, er);
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 1'b1, 1'b0, rd, er);
    chk("model_mask", m_mem[8], 32'h11BB33DD);
    xact(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 1'b0, rd, er);
    chk("t2_mask_rdata", rd, 32'h11BB33DD);

    // Misaligned and out-of-range accesses
    xact(1'b0, 32'h22, 32'h0, 4'h0, 0, 1'b0, 1'b0, rd, er);
    chk("t3_misal_rdata", rd, 32'h0);
    chk1("t3_misal_err", er, 1'b1);
    xact(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 0, 1'b1, 1'b0, rd, er);
    xact(1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, 0, 1'b1, 1'b0, rd, er);
    chk1("t3_oor_err", er, 1'b1);
    xact(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, 1'b0, rd, er);
    chk("t3_no_alias", rd, 32'hA5A5A5A5);
    chk1("t3_no_alias_err", er, 1'b0);

    // Response backpressure with a competing request
    xact(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b0, 1'b1, rd, er);
    chk("t4_bp_rdata", rd, 32'hDEADBEEF);
    xact(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, 1'b0, rd, er);
    chk("t4_word0_kept", rd, 32'hA5A5A5A5);

    // Reset during WAIT abandons the store
    xact(1'b1, 32'h30, 32'h12345678, 4'hF, 0, 1'b1, 1'b0, rd, er);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h30;
    bus.req_wdata = 32'h55; bus.req_wstrb = 4'hF;
    @(negedge clk);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk1("t5_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("t5_busy", busy, 1'b0);
    chk1("t5_req_ready", bus.req_ready, 1'b1);
    chk("t5_rdata", bus.rsp_rdata, 32'h0);
    chk1("t5_err", bus.rsp_err, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    xact(1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, 1'b0, rd, er);
    chk("t5_old_value", rd, 32'h12345678);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (sel == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (sel == 8) a = 32'((DEPTH + $urandom_range(0, 1000)) * 4);
      else               a = $urandom;
      xact(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3),
           1'($urandom), 1'($urandom), rd, er);
    end

    // LATENCY=0 instance: back-to-back accepts every 2 cycles
    bus0.rsp_ready = 1'b1;
    bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 32'h8;
    bus0.req_wdata = 32'hCAFEF00D; bus0.req_wstrb = 4'hF;
    @(negedge clk);
    chk1("t6_idle_ready", bus0.req_ready, 1'b1);
    @(posedge clk); #1;
    bus0.req_write = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk1("t6_req_ready", bus0.req_ready, 1'(k % 2));
      chk1("t6_rsp_valid", bus0.rsp_valid, !(k % 2));
      if (k % 2 == 0) begin
        chk("t6_rdata", bus0.rsp_rdata, (k == 0) ? 32'h0 : 32'hCAFEF00D);
        chk1("t6_err", bus0.rsp_err, 1'b0);
      end
    end
    bus0.req_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
